// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath: default widths, BCD nibble
// size and the binary-to-BCD converter state encoding.
package calc_pkg;

    localparam int W_DEFAULT      = 8;
    localparam int DIGITS_DEFAULT = 3;
    localparam int NIBBLE         = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } conv_state_t;

endpackage

// File: rtl/calc_datapath_if.sv
// Control-word / display bundle between the calculator control side and the
// datapath. The master drives the switch value and the control strobes; the
// slave (datapath) returns the output register and the decoded digits.
interface calc_datapath_if
    import calc_pkg::*;
#(
    parameter int W      = W_DEFAULT,
    parameter int DIGITS = DIGITS_DEFAULT
) ();

    logic [W-1:0]               data_in;
    logic                       ld_a;
    logic                       ld_b;
    logic                       ld_r;
    logic                       add_sub;
    logic                       ld_ou;
    logic                       iu_au;
    logic [W-1:0]               ou_q;
    logic                       ovf;
    logic                       sign;
    logic [NIBBLE*DIGITS-1:0]   bcd;
    logic                       digits_valid;
    logic                       busy;

    modport master (
        output data_in, ld_a, ld_b, ld_r, add_sub, ld_ou, iu_au,
        input  ou_q, ovf, sign, bcd, digits_valid, busy
    );

    modport slave (
        input  data_in, ld_a, ld_b, ld_r, add_sub, ld_ou, iu_au,
        output ou_q, ovf, sign, bcd, digits_valid, busy
    );

endinterface

// File: rtl/bcd_serial.sv
// Serial double-dabble converter: turns a signed W-bit value into a sign flag
// and DIGITS BCD magnitude digits, one bit per cycle. 'start' requests a
// (re)conversion; 'done' marks the cycle the result is committed.
module bcd_serial
    import calc_pkg::*;
#(
    parameter int W      = W_DEFAULT,
    parameter int DIGITS = DIGITS_DEFAULT
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic [W-1:0]               value,
    output logic [W-1:0]               src,
    output logic                       busy,
    output logic                       done,
    output logic                       sign,
    output logic [NIBBLE*DIGITS-1:0]   bcd
);

    localparam int BW = NIBBLE * DIGITS;
    localparam int CW = $clog2(W + 1);

    conv_state_t     state_reg, state_next;
    logic [W-1:0]    src_reg;
    logic [W-1:0]    mag_reg;
    logic [BW-1:0]   scratch_reg;
    logic [CW-1:0]   cnt_reg;
    logic            neg_reg;
    logic [BW-1:0]   bcd_reg;
    logic            sign_reg;
    logic [BW-1:0]   adj;

    // Add-3 correction of every scratch digit that would reach 10 after doubling.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            logic [NIBBLE-1:0] nib;
            assign nib = scratch_reg[gi*NIBBLE +: NIBBLE];
            assign adj[gi*NIBBLE +: NIBBLE] = (nib >= 4'd5) ? (nib + 4'd3) : nib;
        end
    endgenerate

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; a value change seen in DONE chains straight into LOAD.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = LOAD;
            LOAD:    state_next = SHIFT;
            SHIFT:   if (cnt_reg == CW'(1)) state_next = DONE;
            DONE:    state_next = start ? LOAD : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Conversion datapath: capture, shift-and-adjust, and result commit.
    always_ff @(posedge clock) begin
        if (reset) begin
            src_reg     <= '0;
            mag_reg     <= '0;
            scratch_reg <= '0;
            cnt_reg     <= '0;
            neg_reg     <= 1'b0;
            bcd_reg     <= '0;
            sign_reg    <= 1'b0;
        end else begin
            case (state_reg)
                LOAD: begin
                    src_reg     <= value;
                    neg_reg     <= value[W-1];
                    // -2^(W-1) negates to itself, which read unsigned is the right magnitude.
                    mag_reg     <= value[W-1] ? (~value + W'(1)) : value;
                    scratch_reg <= '0;
                    cnt_reg     <= CW'(W);
                end
                SHIFT: begin
                    // Top scratch bit never carries because 10^DIGITS > 2^(W-1).
                    {scratch_reg, mag_reg} <= {adj[BW-2:0], mag_reg, 1'b0};
                    cnt_reg                <= cnt_reg - CW'(1);
                end
                DONE: begin
                    // A stale result is dropped so only current values ever reach the display.
                    if (!start) begin
                        bcd_reg  <= scratch_reg;
                        sign_reg <= neg_reg;
                    end
                end
                default: ;
            endcase
        end
    end

    assign src  = src_reg;
    assign busy = (state_reg != IDLE);
    assign done = (state_reg == DONE) && !start;
    assign sign = sign_reg;
    assign bcd  = bcd_reg;

endmodule

// File: rtl/calc_datapath.sv
// Calculator datapath: operand registers A/B, result register R with signed
// overflow flag, output register OU, and a serial BCD converter that keeps
// the display digits in step with OU.
module calc_datapath
    import calc_pkg::*;
#(
    parameter int W      = W_DEFAULT,
    parameter int DIGITS = DIGITS_DEFAULT
) (
    input  logic            clock,
    input  logic            reset,
    calc_datapath_if.slave  bus
);

    logic [W-1:0]   a_reg;
    logic [W-1:0]   b_reg;
    logic [W-1:0]   r_reg;
    logic [W-1:0]   ou_reg;
    logic           ovf_reg;
    logic           valid_reg;
    logic [W-1:0]   alu;
    logic           alu_ovf;
    logic [W-1:0]   conv_src;
    logic           conv_start;
    logic           conv_busy;
    logic           conv_done;

    // Combinational add/subtract with signed overflow detection.
    always_comb begin
        alu     = bus.add_sub ? (a_reg - b_reg) : (a_reg + b_reg);
        alu_ovf = 1'b0;
        if (bus.add_sub) begin
            alu_ovf = (a_reg[W-1] != b_reg[W-1]) && (alu[W-1] != a_reg[W-1]);
        end else begin
            alu_ovf = (a_reg[W-1] == b_reg[W-1]) && (alu[W-1] != a_reg[W-1]);
        end
    end

    // Operand and result registers; R samples the pre-load A/B on the same edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            a_reg   <= '0;
            b_reg   <= '0;
            r_reg   <= '0;
            ovf_reg <= 1'b0;
        end else begin
            if (bus.ld_a) a_reg <= bus.data_in;
            if (bus.ld_b) b_reg <= bus.data_in;
            if (bus.ld_r) begin
                r_reg   <= alu;
                ovf_reg <= alu_ovf;
            end
        end
    end

    // Output register; bypasses the ALU when R is being loaded on the same edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            ou_reg <= '0;
        end else if (bus.ld_ou) begin
            if (bus.iu_au) begin
                ou_reg <= bus.data_in;
            end else if (bus.ld_r) begin
                ou_reg <= alu;
            end else begin
                ou_reg <= r_reg;
            end
        end
    end

    assign conv_start = (ou_reg != conv_src);

    // Digits are valid from reset (0 is trivially converted) until OU diverges.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_reg <= 1'b1;
        end else if (conv_start) begin
            valid_reg <= 1'b0;
        end else if (conv_done) begin
            valid_reg <= 1'b1;
        end
    end

    bcd_serial #(
        .W      (W),
        .DIGITS (DIGITS)
    ) u_conv (
        .clock  (clock),
        .reset  (reset),
        .start  (conv_start),
        .value  (ou_reg),
        .src    (conv_src),
        .busy   (conv_busy),
        .done   (conv_done),
        .sign   (bus.sign),
        .bcd    (bus.bcd)
    );

    assign bus.ou_q         = ou_reg;
    assign bus.ovf          = ovf_reg;
    assign bus.digits_valid = valid_reg;
    assign bus.busy         = conv_busy;

endmodule

// File: tb/tb_calc_datapath.sv
// Bench for calc_datapath: hand sequences for latency and conversion corner
// cases, a table of control-word vectors, and a randomized run against a
// behavioural model of the register/ALU/display rules.
module tb_calc_datapath;
    import calc_pkg::*;

    localparam int W      = 8;
    localparam int DIGITS = 3;
    localparam int BW     = 4 * DIGITS;

    logic clock = 1'b0;
    logic reset = 1'b1;

    calc_datapath_if #(.W(W), .DIGITS(DIGITS)) bus ();

    calc_datapath #(.W(W), .DIGITS(DIGITS)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        la, lb, lr, as, lo, iu;
        logic [W-1:0] d;
        logic [W-1:0] exp_ou;
        logic        exp_ovf;
    } vec_t;

    vec_t tbl[16];

    // Behavioural model state
    logic [W-1:0] m_a, m_b, m_r, m_ou;
    logic         m_ovf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic la, input logic lb, input logic lr, input logic as,
                         input logic lo, input logic iu, input logic [W-1:0] d);
        bus.ld_a    = la;
        bus.ld_b    = lb;
        bus.ld_r    = lr;
        bus.add_sub = as;
        bus.ld_ou   = lo;
        bus.iu_au   = iu;
        bus.data_in = d;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, '0);
    endtask

    // Decimal digits of |v| computed with integer arithmetic.
    function automatic logic [BW-1:0] ref_bcd(input logic [W-1:0] v);
        int s;
        int mag;
        logic [BW-1:0] r;
        s   = int'($signed(v));
        mag = (s < 0) ? -s : s;
        r   = '0;
        for (int k = 0; k < DIGITS; k++) begin
            r[k*4 +: 4] = 4'(mag % 10);
            mag = mag / 10;
        end
        return r;
    endfunction

    function automatic logic ref_sign(input logic [W-1:0] v);
        return int'($signed(v)) < 0;
    endfunction

    // Model of one clock edge with the given control word.
    task automatic model_apply(input logic la, input logic lb, input logic lr, input logic as,
                               input logic lo, input logic iu, input logic [W-1:0] d);
        int sum;
        logic [W-1:0] res;
        logic o;
        sum = as ? (int'($signed(m_a)) - int'($signed(m_b)))
                 : (int'($signed(m_a)) + int'($signed(m_b)));
        res = sum[W-1:0];
        o   = (sum > (2**(W-1) - 1)) || (sum < -(2**(W-1)));
        if (lo) m_ou = iu ? d : (lr ? res : m_r);
        if (lr) begin
            m_r   = res;
            m_ovf = o;
        end
        if (la) m_a = d;
        if (lb) m_b = d;
    endtask

    task automatic check_display(input string name, input logic [W-1:0] v);
        check({name, " valid"}, bus.digits_valid, 1'b1);
        check({name, " busy"},  bus.busy, 1'b0);
        check({name, " bcd"},   bus.bcd, ref_bcd(v));
        check({name, " sign"},  bus.sign, ref_sign(v));
    endtask

    // Load OU directly from the switches and check the display after the full latency.
    task automatic convert_check(input logic [W-1:0] v);
        drive(0, 0, 0, 0, 1, 1, v);
        step();
        idle();
        for (int k = 0; k < W + 3; k++) step();
        check_display("conv", v);
        $display("conv ou=%02h bcd=%03h sign=%0d", bus.ou_q, bus.bcd, bus.sign);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd10,  8'd42,  1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd30,  8'd42,  1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0,   8'hEC,  1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd100, 8'hEC,  1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd100, 8'hEC,  1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   8'hEC,  1'b1};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0,   8'hC8,  1'b1};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h80,  8'hC8,  1'b1};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1,   8'hC8,  1'b1};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0,   8'h7F,  1'b1};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd5,   8'h81,  1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0,   8'h81,  1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0,   8'h06,  1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h80,  8'h80,  1'b0};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd3,   8'h03,  1'b0};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0,   8'h04,  1'b0};

        idle();
        step();
        step();

        // Reset state
        check("rst ou_q", bus.ou_q, 8'h00);
        check("rst ovf", bus.ovf, 1'b0);
        check("rst sign", bus.sign, 1'b0);
        check("rst bcd", bus.bcd, 12'h000);
        check("rst valid", bus.digits_valid, 1'b1);
        check("rst busy", bus.busy, 1'b0);
        reset = 1'b0;

        // 25 + 17 with bypass into OU, then exact conversion latency
        drive(1, 0, 0, 0, 0, 0, 8'd25);
        step();
        step();
        drive(0, 1, 0, 0, 0, 0, 8'd17);
        step();
        drive(0, 0, 1, 0, 1, 0, 8'd0);
        step();
        idle();
        check("add ou_q", bus.ou_q, 8'd42);
        check("add ovf", bus.ovf, 1'b0);
        check("add valid t", bus.digits_valid, 1'b1);
        step();
        check("add valid t+1", bus.digits_valid, 1'b0);
        check("add busy t+1", bus.busy, 1'b1);
        for (int k = 0; k < W + 1; k++) step();
        check("add valid t+W+2", bus.digits_valid, 1'b0);
        step();
        check("add valid t+W+3", bus.digits_valid, 1'b1);
        check("add bcd", bus.bcd, 12'h042);
        check("add sign", bus.sign, 1'b0);
        check("add busy end", bus.busy, 1'b0);
        $display("seq add ou=%02h bcd=%03h", bus.ou_q, bus.bcd);

        // Table of control words, one cycle each
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].la, tbl[i].lb, tbl[i].lr, tbl[i].as, tbl[i].lo, tbl[i].iu, tbl[i].d);
            step();
            check($sformatf("vec%0d ou_q", i), bus.ou_q, tbl[i].exp_ou);
            check($sformatf("vec%0d ovf", i), bus.ovf, tbl[i].exp_ovf);
            $display("vec %0d ou=%02h ovf=%0d", i, bus.ou_q, bus.ovf);
        end
        idle();
        for (int k = 0; k < 2 * (W + 3) + 2; k++) step();
        check_display("vec settle", 8'h04);

        // Display of negative values including the most negative one
        convert_check(8'hEC);
        check("neg20 bcd", bus.bcd, 12'h020);
        convert_check(8'h80);
        check("min bcd", bus.bcd, 12'h128);
        check("min sign", bus.sign, 1'b1);
        convert_check(8'h7F);

        // OU changes mid-conversion: 5 then 99 two cycles later
        drive(0, 0, 0, 0, 1, 1, 8'd5);
        step();
        idle();
        step();
        check("tog busy e1", bus.busy, 1'b1);
        check("tog valid e1", bus.digits_valid, 1'b0);
        drive(0, 0, 0, 0, 1, 1, 8'd99);
        step();
        idle();
        for (int k = 2; k < 2 * W + 5; k++) begin
            check($sformatf("tog busy e%0d", k), bus.busy, 1'b1);
            check($sformatf("tog valid e%0d", k), bus.digits_valid, 1'b0);
            step();
        end
        check("tog valid end", bus.digits_valid, 1'b1);
        check("tog busy end", bus.busy, 1'b0);
        check("tog bcd", bus.bcd, 12'h099);
        check("tog sign", bus.sign, 1'b0);
        $display("seq toggle bcd=%03h", bus.bcd);

        // Reset while shifting, then an identical reload
        drive(0, 0, 0, 0, 1, 1, 8'd77);
        step();
        idle();
        for (int k = 0; k < 4; k++) step();
        check("pre-rst busy", bus.busy, 1'b1);
        reset = 1'b1;
        step();
        check("mid-rst ou_q", bus.ou_q, 8'h00);
        check("mid-rst bcd", bus.bcd, 12'h000);
        check("mid-rst busy", bus.busy, 1'b0);
        check("mid-rst valid", bus.digits_valid, 1'b1);
        check("mid-rst sign", bus.sign, 1'b0);
        check("mid-rst ovf", bus.ovf, 1'b0);
        reset = 1'b0;
        drive(0, 0, 0, 0, 1, 1, 8'd0);
        step();
        idle();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("same busy %0d", k), bus.busy, 1'b0);
            check($sformatf("same valid %0d", k), bus.digits_valid, 1'b1);
            step();
        end
        $display("seq reset ou=%02h busy=%0d", bus.ou_q, bus.busy);

        // Randomized control words against the model
        m_a = '0; m_b = '0; m_r = '0; m_ou = '0; m_ovf = 1'b0;
        for (int t = 0; t < 40; t++) begin
            logic la, lb, lr, as, lo, iu;
            logic [W-1:0] d;
            la = 1'($urandom_range(0, 1));
            lb = 1'($urandom_range(0, 1));
            lr = 1'($urandom_range(0, 1));
            as = 1'($urandom_range(0, 1));
            lo = 1'($urandom_range(0, 1));
            iu = 1'($urandom_range(0, 1));
            d  = W'($urandom);
            drive(la, lb, lr, as, lo, iu, d);
            model_apply(la, lb, lr, as, lo, iu, d);
            step();
            idle();
            check($sformatf("rnd%0d ou_q", t), bus.ou_q, m_ou);
            check($sformatf("rnd%0d ovf", t), bus.ovf, m_ovf);
            for (int k = 0; k < W + 3; k++) step();
            check_display($sformatf("rnd%0d", t), m_ou);
            $display("rnd %0d ctl=%b%b%b%b%b%b d=%02h ou=%02h ovf=%0d bcd=%03h sign=%0d",
                     t, la, lb, lr, as, lo, iu, d, bus.ou_q, bus.ovf, bus.bcd, bus.sign);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
